// File: rtl/mau_pkg.sv
// mau_pkg: shared definitions for the MEM-stage load/store initiator.
//   state_t          FSM encoding (IDLE, RD, WR, DONE)
//   SIZE_B/H/W/R     req_size encodings (R = reserved)
//   byte_shift()     bit position of a big-endian byte lane
//   half_shift()     bit position of a big-endian halfword lane
package mau_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;
    localparam logic [1:0] SIZE_R = 2'b11;

    // Big-endian: offset 0 is the most significant byte (bits 31:24).
    function automatic logic [4:0] byte_shift(input logic [1:0] off);
        return {~off, 3'b000};
    endfunction

    // Offset 0 selects bits 31:16, offset 2 selects bits 15:0.
    function automatic logic [4:0] half_shift(input logic [1:0] off);
        return {~off[1], 4'b0000};
    endfunction

endpackage

// File: rtl/mau_lane.sv
// mau_lane: combinational lane logic for the memory access unit.
//   size, off     access size and byte offset inside the word
//   is_unsigned   zero-extend sub-word loads instead of sign-extending
//   word          memory word (read data)
//   wdata         right-justified store data
//   load_data     selected lane, right-justified and extended
//   merged        word with the target lane(s) replaced by wdata
module mau_lane
    import mau_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  off,
    input  logic        is_unsigned,
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [4:0]         bsh;
    logic [4:0]         hsh;
    logic signed [7:0]  byte_sel;
    logic signed [15:0] half_sel;

    always_comb begin
        bsh       = byte_shift(off);
        hsh       = half_shift(off);
        byte_sel  = word[bsh +: 8];
        half_sel  = word[hsh +: 16];
        load_data = word;
        merged    = wdata;
        case (size)
            SIZE_B: begin
                load_data = is_unsigned ? {24'b0, byte_sel} : 32'(byte_sel);
                merged    = word;
                merged[bsh +: 8] = wdata[7:0];
            end
            SIZE_H: begin
                load_data = is_unsigned ? {16'b0, half_sel} : 32'(half_sel);
                merged    = word;
                merged[hsh +: 16] = wdata[15:0];
            end
            default: begin
                load_data = word;
                merged    = wdata;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store initiator for a 5-stage MIPS pipeline.
// Turns byte/half/word loads and stores into word-only memory cycles on a
// big-endian, byte-addressed data memory; sub-word stores are read-modify-write.
// The pipeline is stalled until the access reaches DONE.
//
// Build option: MAU_MISALIGN_TRAP_EN
//   defined   misaligned half/word and size 11 are trapped (resp_err=1, no access)
//   undefined low address bits are forced to alignment, size 11 acts as word
//
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   req_valid/write/size/unsigned request from the EX/MEM register
//   req_addr, req_wdata           byte address, right-justified store data
//   mem_addr/wdata/we/re          word-wide data memory port
//   mem_rdata                     combinational read data for mem_addr
//   stall                         freeze upstream pipeline registers
//   resp_valid/rdata/err          one-cycle completion with load result/error
module mem_access_unit
    import mau_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    output logic        mem_re,
    input  logic [31:0] mem_rdata,
    output logic        stall,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    state_t      state;
    state_t      state_nxt;

    logic        write_q;
    logic        uns_q;
    logic        err_q;
    logic [1:0]  size_q;
    logic [1:0]  off_q;
    logic [29:0] waddr_q;
    logic [31:0] wdata_q;
    logic [31:0] word_q;

    logic        misaligned;
    logic [1:0]  size_eff;
    logic [1:0]  off_eff;
    logic [31:0] load_data;
    logic [31:0] merged;

    // Request qualification: decide trap vs. forced alignment before latching.
    always_comb begin
        size_eff   = req_size;
        off_eff    = req_addr[1:0];
        misaligned = 1'b0;
`ifdef MAU_MISALIGN_TRAP_EN
        misaligned = (req_size == SIZE_H && req_addr[0]) ||
                     (req_size == SIZE_W && req_addr[1:0] != 2'b00) ||
                     (req_size == SIZE_R);
`else
        if (req_size == SIZE_R)
            size_eff = SIZE_W;
        if (size_eff == SIZE_H)
            off_eff = {req_addr[1], 1'b0};
        else if (size_eff == SIZE_W)
            off_eff = 2'b00;
`endif
    end

    // Control state: the only reset register.
    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Request latch (accept cycle) and read-word capture (end of RD).
    always_ff @(posedge clk) begin
        if (state == IDLE && req_valid) begin
            write_q <= req_write;
            uns_q   <= req_unsigned;
            err_q   <= misaligned;
            size_q  <= size_eff;
            off_q   <= off_eff;
            waddr_q <= req_addr[31:2];
            wdata_q <= req_wdata;
        end
        if (state == RD)
            word_q <= mem_rdata;
    end

    mau_lane u_lane (
        .size        (size_q),
        .off         (off_q),
        .is_unsigned (uns_q),
        .word        (word_q),
        .wdata       (wdata_q),
        .load_data   (load_data),
        .merged      (merged)
    );

    always_comb begin
        state_nxt  = state;
        mem_addr   = 32'b0;
        mem_wdata  = 32'b0;
        mem_we     = 1'b0;
        mem_re     = 1'b0;
        resp_valid = 1'b0;
        resp_rdata = 32'b0;
        resp_err   = 1'b0;
        stall      = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    stall = 1'b1;
                    if (misaligned)
                        state_nxt = DONE;
                    else if (!req_write || size_eff != SIZE_W)
                        state_nxt = RD;
                    else
                        state_nxt = WR;
                end
            end
            RD: begin
                stall     = 1'b1;
                mem_re    = !reset;
                mem_addr  = {waddr_q, 2'b00};
                state_nxt = write_q ? WR : DONE;
            end
            WR: begin
                stall     = 1'b1;
                mem_we    = !reset;
                mem_addr  = {waddr_q, 2'b00};
                mem_wdata = merged;
                state_nxt = DONE;
            end
            DONE: begin
                resp_valid = 1'b1;
                resp_err   = err_q;
                resp_rdata = (write_q || err_q) ? 32'b0 : load_data;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule
